// File: rtl/n64_pkg.sv
// Shared N64 controller-link definitions: bit timing, response width and the
// receiver state encoding used by the read-response block.
package n64_pkg;

  // Nominal bit timing at 100 MHz (clk per phase boundary inside a 4 us bit)
  localparam int T_START        = 100;
  localparam int T_DATA         = 300;
  localparam int T_STOP         = 400;
  localparam int T_SAMPLE       = 200;
  localparam int T_LOW_MAX      = 350;
  localparam int T_HIGH_MAX     = 600;
  localparam int T_RESP_TIMEOUT = 20000;

  localparam int RESP_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    LOW,
    DONE,
    ERR
  } rx_state_t;

  function automatic bit fits_cnt(input int v);
    return (v >= 0) && (v < (1 << CNT_W));
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the open-drain controller line plus a falling-edge
// strobe on the synchronized value.
module n64_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic line_s,
  output logic fall_s
);

  logic meta_q, sync_q, prev_q;

  // Idle-high reset keeps a released line from looking like an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= data_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_s = sync_q;
  assign fall_s = prev_q & ~sync_q;

endmodule

// File: rtl/n64_read_response.sv
// Receiver half of the N64 single-wire link: times each controller bit from its
// falling edge, samples at mid-bit and assembles the LSB-first response word.
module n64_read_response
  import n64_pkg::*;
#(
  parameter int NUM_BITS     = RESP_W,
  parameter int SAMPLE_POINT = T_SAMPLE,
  parameter int LOW_MAX      = T_LOW_MAX,
  parameter int HIGH_MAX     = T_HIGH_MAX,
  parameter int RESP_TIMEOUT = T_RESP_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                data_in,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_error,
  output logic                busy
);

  localparam int IDX_W = $clog2(NUM_BITS + 1);

  if (!fits_cnt(SAMPLE_POINT) || !fits_cnt(LOW_MAX) || !fits_cnt(HIGH_MAX) ||
      !fits_cnt(RESP_TIMEOUT) || (SAMPLE_POINT >= LOW_MAX) || (NUM_BITS < 1)) begin : g_param_check
    $error("n64_read_response: timing parameters must fit the 16-bit counter and SAMPLE_POINT < LOW_MAX");
  end

  localparam logic [CNT_W-1:0] C_SAMPLE  = CNT_W'(SAMPLE_POINT);
  localparam logic [CNT_W-1:0] C_LOW_MAX = CNT_W'(LOW_MAX);
  localparam logic [CNT_W-1:0] C_HIGH    = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(RESP_TIMEOUT);
  localparam logic [IDX_W-1:0] STOP_IDX  = IDX_W'(NUM_BITS);

  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      wait_lim;
  logic [IDX_W-1:0]      bit_idx;
  logic [NUM_BITS-1:0]   shreg;
  logic                  line_s;
  logic                  fall_s;

  n64_line_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .data_in (data_in),
    .line_s  (line_s),
    .fall_s  (fall_s)
  );

  assign cnt_inc  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  // Only the first bit gets the long response window
  assign wait_lim = (bit_idx == '0) ? C_TIMEOUT : C_HIGH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= WAIT_FALL;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end

        WAIT_FALL: begin
          if (fall_s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt >= wait_lim) begin
            state    <= ERR;
            rx_error <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        LOW: begin
          cnt <= cnt_inc;
          if (cnt == C_SAMPLE) begin
            if (bit_idx == STOP_IDX) begin
              // Stop bit decides the frame right at its sample point
              if (line_s) begin
                state    <= DONE;
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                state    <= ERR;
                rx_error <= 1'b1;
              end
            end else begin
              shreg <= {line_s, shreg[NUM_BITS-1:1]};
              if (line_s) begin
                state   <= WAIT_FALL;
                cnt     <= '0;
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end else if ((cnt > C_SAMPLE) && line_s) begin
            state   <= WAIT_FALL;
            cnt     <= '0;
            bit_idx <= bit_idx + IDX_W'(1);
          end else if (cnt >= C_LOW_MAX) begin
            state    <= ERR;
            rx_error <= 1'b1;
          end
        end

        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_read_response.sv
// Bench for n64_read_response: a frame-level model predicts busy/valid/error and
// rx_data every cycle from the drive schedule; literal checks pin key latencies.
module tb_n64_read_response;

  localparam int NB      = 32;
  localparam int SP      = 200;
  localparam int LMAX    = 350;
  localparam int HMAX    = 600;
  localparam int TOUT    = 20000;
  localparam int INF     = 32'h7FFF_FFFF;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          en      = 1'b0;
  logic          data_in = 1'b1;
  logic [NB-1:0] rx_data;
  logic          rx_valid, rx_error, busy;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;

  // Frame-level model: busy window [m_start, m_end], outcome m_kind at m_end
  bit          m_armed = 1'b0;
  int          m_start = 0, m_end = INF, m_kind = 0;
  logic [31:0] m_data = '0, m_rx = '0;

  int obs_v = 0, obs_e = 0, obs_rise = 0, obs_fall = 0;
  int n_valid = 0, n_err = 0;
  bit busy_q = 1'b0, chk_en = 1'b0, hit = 1'b0;
  int g_fall = 0, nv = 0, ne = 0;

  n64_read_response #(
    .NUM_BITS(NB), .SAMPLE_POINT(SP), .LOW_MAX(LMAX),
    .HIGH_MAX(HMAX), .RESP_TIMEOUT(TOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .data_in  (data_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic eb, ev, ee;
    if (chk_en) begin
      eb = m_armed && (cyc >= m_start) && (cyc <= m_end);
      ev = m_armed && (m_kind == K_VALID) && (cyc == m_end);
      ee = m_armed && (m_kind == K_ERR) && (cyc == m_end);
      if (ev) m_rx = m_data;
      n_tests++;
      if (busy !== eb || rx_valid !== ev || rx_error !== ee || rx_data !== m_rx) begin
        n_fail++;
        $display("FAIL cycle_check @%0d: busy %b/%b valid %b/%b error %b/%b rx_data %h/%h (got/required)",
                 cyc, busy, eb, rx_valid, ev, rx_error, ee, rx_data, m_rx);
      end
      if (rx_valid) begin n_valid++; obs_v = cyc; end
      if (rx_error) begin n_err++; obs_e = cyc; end
      if (busy && !busy_q) obs_rise = cyc;
      if (!busy && busy_q) obs_fall = cyc;
      busy_q = busy;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic arm();
    @(posedge clk); #1;
    en = 1'b1;
    m_armed = 1'b1; m_start = cyc + 1; m_end = cyc + 2 + TOUT; m_kind = K_ERR;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // role: 0 data bit, 1 first bit, 2 stop bit
  task automatic drive_bit(input bit v, input int jl, input int jh, input int role);
    int lo, hi;
    lo = (v ? 100 : 300) + jl;
    hi = (v ? 300 : 100) + jh;
    @(posedge clk); #1;
    data_in = 1'b0; g_fall = cyc;
    if (role == 1) m_end = INF;
    if (role == 2) begin m_end = cyc + 4 + SP; m_kind = v ? K_VALID : K_ERR; end
    repeat (lo) @(posedge clk);
    #1 data_in = 1'b1;
    repeat (hi - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d, input bit stop_v, input bit jit,
                            input int stuck, input int abort_at);
    int jl, jh;
    bit v;
    m_data = d;
    repeat (50) @(posedge clk);
    for (int i = 0; i <= NB; i++) begin
      jl = jit ? ((i * 17) % 61) - 30 : 0;
      jh = jit ? ((i * 29 + 7) % 61) - 30 : 0;
      if (i == stuck) begin
        @(posedge clk); #1;
        data_in = 1'b0; g_fall = cyc;
        m_end = cyc + 4 + LMAX; m_kind = K_ERR;
        repeat (400) @(posedge clk);
        #1 data_in = 1'b1;
        return;
      end
      if (i == abort_at) begin
        @(posedge clk); #1;
        data_in = 1'b0;
        repeat (50) @(posedge clk);
        #1 reset_n = 1'b0;
        data_in = 1'b1; m_armed = 1'b0; m_rx = '0;
        #1;
        check("reset_rx_data", rx_data, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_valid", {31'b0, rx_valid}, 32'h0);
        check("reset_error", {31'b0, rx_error}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        return;
      end
      v = (i == NB) ? stop_v : d[i[4:0]];
      drive_bit(v, jl, jh, (i == 0) ? 1 : ((i == NB) ? 2 : 0));
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 25000 && !ok; k++) begin
      if (m_end != INF && cyc > m_end + 1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: frame end not reached, cycle %0d required end %0d", name, cyc, m_end);
    end
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("init_rx_data", rx_data, 32'h0);
    check("init_busy", {31'b0, busy}, 32'h0);
    check("init_valid", {31'b0, rx_valid}, 32'h0);
    check("init_error", {31'b0, rx_error}, 32'h0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (5) @(posedge clk);

    // Line stuck low 400 clk in bit 5
    arm();
    send_frame(32'hA5C3_0F81, 1'b1, 1'b0, 5, -1);
    wait_done("stuck_low");
    check("stuck_low_latency", obs_e - g_fall, 32'd354);
    check("stuck_low_err_count", n_err, 32'd1);

    // Jittered clean frame, accepted right after the error
    arm();
    send_frame(32'hA5C3_0F81, 1'b1, 1'b1, -1, -1);
    wait_done("jitter_frame");
    check("jitter_rx_data", rx_data, 32'hA5C3_0F81);
    check("jitter_valid_latency", obs_v - g_fall, 32'd204);
    check("jitter_no_error", n_err, 32'd1);

    // Response timeout with the line left high
    arm();
    wait_done("timeout");
    check("timeout_latency", obs_e - obs_rise, 32'd20001);
    check("timeout_keeps_data", rx_data, 32'hA5C3_0F81);

    // Bad stop bit, with en pulsed mid-frame and in the error cycle
    nv = n_valid; ne = n_err; hit = 1'b0;
    arm();
    fork
      send_frame(32'h5A5A_1234, 1'b0, 1'b0, -1, -1);
      begin
        repeat (6000) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        for (int k = 0; k < 20000 && !hit; k++) begin
          @(posedge clk); #1;
          if (cyc == m_end) hit = 1'b1;
        end
        if (hit) begin
          en = 1'b1;
          @(posedge clk);
          #1 en = 1'b0;
        end
      end
    join
    check("stop_err_cycle_reached", {31'b0, hit}, 32'h1);
    wait_done("bad_stop");
    repeat (20) @(posedge clk);
    #1;
    check("bad_stop_no_valid", n_valid - nv, 32'd0);
    check("bad_stop_one_error", n_err - ne, 32'd1);
    check("bad_stop_keeps_data", rx_data, 32'hA5C3_0F81);

    // Reset mid bit 17
    arm();
    send_frame(32'hFFFF_0000, 1'b1, 1'b0, -1, 17);
    nv = n_valid; ne = n_err;
    repeat (100) @(posedge clk);
    #1;
    check("post_reset_no_pulses", (n_valid - nv) + (n_err - ne), 32'd0);

    // Fresh nominal frame 0x0000_0001
    arm();
    send_frame(32'h0000_0001, 1'b1, 1'b0, -1, -1);
    wait_done("frame_one");
    check("one_rx_data", rx_data, 32'h0000_0001);
    check("one_valid_latency", obs_v - g_fall, 32'd204);
    check("one_busy_falls_next", obs_fall - obs_v, 32'd1);

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
